// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller: FSM states, blanking
// constants and the active-low hex font.
package fnd_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    localparam logic [7:0] FONT_BLANK = 8'hFF;
    localparam logic [3:0] DIGIT_OFF  = 4'hF;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low, dp off
    localparam logic [7:0] FONT_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/fnd_hex_decoder.sv
// Combinational hex-to-segment decoder; a lit decimal point pulls bit 7 low.
module fnd_hex_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_font
);

    always_comb begin
        o_font    = FONT_TABLE[i_nibble];
        o_font[7] = FONT_TABLE[i_nibble][7] & ~i_dp;
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit common-anode FND scanner with per-slot blanking dead-time,
// frame-boundary data commit and leading-zero suppression.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dp,
    input  logic [3:0]  i_digit_en,
    input  logic        i_lz_en,
    input  logic        i_load,
    output logic [3:0]  o_fndDigit,
    output logic [7:0]  o_fndFont,
    output logic [1:0]  o_fndDigitCnt,
    output logic        o_frame_done
);

    localparam int DIGIT_CYCLES = CLK_HZ / SCAN_HZ;
    localparam int CW           = $clog2(DIGIT_CYCLES);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(DIGIT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     pend_val_q, pend_val_d;
    logic [3:0]      pend_dp_q, pend_dp_d;
    logic [15:0]     shd_val_q, shd_val_d;
    logic [3:0]      shd_dp_q, shd_dp_d;
    logic [3:0]      digit_q, digit_d;
    logic [7:0]      font_q, font_d;
    logic            frame_done_q, frame_done_d;

    logic            wrap;
    logic            hz;
    logic [3:0]      supp;
    logic [3:0]      sel_nibble;
    logic            sel_dp;
    logic [7:0]      dec_font;

    fnd_hex_decoder u_dec (
        .i_nibble (sel_nibble),
        .i_dp     (sel_dp),
        .o_font   (dec_font)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CW'(1);
        idx_d        = idx_q;
        wrap         = 1'b0;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        shd_val_d    = shd_val_q;
        shd_dp_d     = shd_dp_q;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    wrap    = (idx_q == 2'd3);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        if (i_load) begin
            pend_val_d = i_value;
            pend_dp_d  = i_dp;
        end

        // A load landing on the wrap edge goes straight into the shadow
        if (wrap) begin
            shd_val_d = pend_val_d;
            shd_dp_d  = pend_dp_d;
        end

        frame_done_d = wrap;
    end

    // Outputs are computed from next-state values so they line up with the FSM
    always_comb begin
        supp = '0;
        hz   = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            hz      = hz & (shd_val_d[k*4 +: 4] == 4'h0);
            supp[k] = i_lz_en & hz & ~shd_dp_d[k];
        end

        sel_nibble = shd_val_d[{idx_d, 2'b00} +: 4];
        sel_dp     = shd_dp_d[idx_d];

        digit_d = DIGIT_OFF;
        font_d  = FONT_BLANK;
        if (state_d == ST_DRIVE && i_digit_en[idx_d] && !supp[idx_d]) begin
            digit_d = ~(4'b0001 << idx_d);
            font_d  = dec_font;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            shd_val_q    <= '0;
            shd_dp_q     <= '0;
            digit_q      <= DIGIT_OFF;
            font_q       <= FONT_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            shd_val_q    <= shd_val_d;
            shd_dp_q     <= shd_dp_d;
            digit_q      <= digit_d;
            font_q       <= font_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_fndDigit    = digit_q;
    assign o_fndFont     = font_q;
    assign o_fndDigitCnt = idx_q;
    assign o_frame_done  = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: a cycle-count reference model queues the
// expected pin state for every cycle and a negedge monitor compares it.
module tb_fnd_scan_ctrl;

    localparam int CLK_HZ       = 1000;
    localparam int SCAN_HZ      = 100;
    localparam int BLANK_CYCLES = 2;
    localparam int SLOT         = CLK_HZ / SCAN_HZ;
    localparam int FRAME        = 4 * SLOT;

    localparam logic [7:0] SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        lz_en;
    logic        load;
    logic [3:0]  fnd_digit;
    logic [7:0]  fnd_font;
    logic [1:0]  fnd_cnt;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [14:0] exp_q [$];

    fnd_scan_ctrl #(
        .CLK_HZ       (CLK_HZ),
        .SCAN_HZ      (SCAN_HZ),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_value       (value),
        .i_dp          (dp),
        .i_digit_en    (digit_en),
        .i_lz_en       (lz_en),
        .i_load        (load),
        .o_fndDigit    (fnd_digit),
        .o_fndFont     (fnd_font),
        .o_fndDigitCnt (fnd_cnt),
        .o_frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: cycle t since reset release decides slot, phase and commit
    int          t = 0;
    logic [15:0] m_pend, m_shv;
    logic [3:0]  m_pdp, m_shdp;

    always @(posedge clk) begin : model
        int         slot;
        int         phase;
        logic [3:0] dig;
        logic [7:0] fnt;
        logic [3:0] nib;
        logic       sup;
        if (rst) begin
            t      = 0;
            m_pend = '0;
            m_pdp  = '0;
            m_shv  = '0;
            m_shdp = '0;
            exp_q.push_back({4'hF, 8'hFF, 2'd0, 1'b0});
        end else begin
            if (load) begin
                m_pend = value;
                m_pdp  = dp;
            end
            if (t % FRAME == FRAME - 1) begin
                m_shv  = m_pend;
                m_shdp = m_pdp;
            end
            t     = t + 1;
            slot  = (t / SLOT) % 4;
            phase = t % SLOT;
            nib   = m_shv[slot*4 +: 4];
            sup   = lz_en && (slot > 0) && ((m_shv >> (4 * slot)) == 16'h0) && !m_shdp[slot];
            dig   = 4'hF;
            fnt   = 8'hFF;
            if (phase >= BLANK_CYCLES && digit_en[slot] && !sup) begin
                dig = 4'hF & ~(4'h1 << slot);
                fnt = SEG[nib];
                if (m_shdp[slot]) fnt[7] = 1'b0;
            end
            exp_q.push_back({dig, fnt, 2'(slot), (t % FRAME == 0)});
        end
    end

    task automatic checkOutput(input string name, input logic [14:0] act, input logic [14:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s t=%0d got digit=%h font=%h cnt=%0d fd=%0b expected digit=%h font=%h cnt=%0d fd=%0b",
                     name, t, act[14:11], act[10:3], act[2:1], act[0],
                     expv[14:11], expv[10:3], expv[2:1], expv[0]);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [14:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("scan_out", {fnd_digit, fnd_font, fnd_cnt, frame_done}, e);
        end
    end

    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d,
                                 input logic lz, input logic [3:0] en, input logic ld);
        value    = v;
        dp       = d;
        lz_en    = lz;
        digit_en = en;
        load     = ld;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Park in the cycle whose frame position is p; the next edge closes it
    task automatic waitPhase(input int p);
        int guard;
        guard = 0;
        while (t % FRAME != p && guard < 2 * FRAME) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (t % FRAME != p) begin
            errors++;
            $display("[TB] FAIL waitPhase got pos=%0d expected pos=%0d", t % FRAME, p);
        end
    endtask

    initial begin : stimulus
        int ng;
        rst      = 1'b1;
        value    = '0;
        dp       = '0;
        digit_en = 4'hF;
        lz_en    = 1'b0;
        load     = 1'b0;
        runCycles(3);
        rst = 1'b0;

        $display("[TB] load 1234, all digits enabled");
        applyStimulus(16'h1234, 4'h0, 1'b0, 4'hF, 1'b1);
        runCycles(100);

        $display("[TB] leading-zero suppression with 0075");
        applyStimulus(16'h0075, 4'h0, 1'b1, 4'hF, 1'b1);
        runCycles(90);
        applyStimulus(16'h0075, 4'b0100, 1'b1, 4'hF, 1'b1);
        runCycles(90);

        $display("[TB] mid-frame load of AAAA while digit 1 drives");
        waitPhase(15);
        applyStimulus(16'hAAAA, 4'h0, 1'b0, 4'hF, 1'b1);
        runCycles(90);

        $display("[TB] BEEF loaded on the wrap edge");
        waitPhase(FRAME - 1);
        applyStimulus(16'hBEEF, 4'h0, 1'b0, 4'hF, 1'b1);
        runCycles(50);

        $display("[TB] digit enables 0101");
        applyStimulus(16'hBEEF, 4'h0, 1'b0, 4'b0101, 1'b0);
        runCycles(90);
        digit_en = 4'hF;

        $display("[TB] reset during digit 2 drive");
        applyStimulus(16'h5678, 4'h0, 1'b0, 4'hF, 1'b1);
        waitPhase(25);
        rst = 1'b1;
        runCycles(1);
        rst = 1'b0;
        runCycles(45);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 9) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 29) == 0) lz_en = 1'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                ng    = $urandom_range(0, 4);
                value = 16'($urandom) >> (4 * ng);
                dp    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                load  = 1'b1;
            end
            rst = ($urandom_range(0, 399) == 0);
            runCycles(1);
            load = 1'b0;
            rst  = 1'b0;
        end

        runCycles(2);
        checks++;
        if (exp_q.size() > 1) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d pending expected at most 1", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
